stream_vector_accumulator: RTL and testbench



---
 rtl/lstm_fixed_pkg.sv | 29 ++
 rtl/stream_vector_accumulator_if.sv | 27 ++
 rtl/fixed_saturate.sv | 24 ++
 rtl/stream_vector_accumulator.sv | 107 ++++++++++
 tb/tb_stream_vector_accumulator.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lstm_fixed_pkg.sv
// Shared fixed-point definitions for the LSTM datapath: default widths,
// accumulator FSM states and the saturating narrow used by every accumulator.
package lstm_fixed_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int FRACT_WIDTH_DEF = 8;

  localparam logic [DATA_WIDTH_DEF-1:0] FIXED_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH_DEF-1:0] FIXED_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Clip a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/stream_vector_accumulator_if.sv
// Input word stream and output result stream of the vector accumulator.
interface stream_vector_accumulator_if
  import lstm_fixed_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 9
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  out_count;
  logic                  out_sat;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_count, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_count, out_sat, out_valid
  );
endinterface

// File: rtl/fixed_saturate.sv
// Combinational narrowing of a wide signed accumulator to a signed word,
// clipping to the word range and flagging when clipping happened.
module fixed_saturate
  import lstm_fixed_pkg::*;
#(
  parameter int IN_WIDTH  = 25,
  parameter int OUT_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [IN_WIDTH-1:0] value,
  output logic [OUT_WIDTH-1:0]       result,
  output logic                       sat
);

  logic signed [63:0] wide;
  logic signed [63:0] clipped;

  always_comb begin
    wide    = {{(64-IN_WIDTH){value[IN_WIDTH-1]}}, value};
    clipped = sat_narrow(wide, OUT_WIDTH);
    result  = clipped[OUT_WIDTH-1:0];
    sat     = (clipped != wide);
  end

endmodule

// File: rtl/stream_vector_accumulator.sv
// Serial vector adder: sums up to N_IN signed words from a valid/ready stream
// and emits one saturated word per vector on a valid/ready result port.
//
//  state | meaning
//  IDLE  | waiting for the first word of a vector; next word replaces acc
//  ACCUM | adding words; ends on in_last or when N_IN words are in
//  DONE  | result held on the output until out_ready; input stalled
module stream_vector_accumulator
  import lstm_fixed_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
  parameter int N_IN        = 500,
  parameter int ACC_WIDTH   = DATA_WIDTH + $clog2(N_IN),
  parameter int CNT_WIDTH   = $clog2(N_IN + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  stream_vector_accumulator_if.slave bus
);

  generate
    if (FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
      $error("FRACT_WIDTH must lie in [0, DATA_WIDTH)");
    end
  endgenerate

  acc_state_t state, next_state;

  logic signed [ACC_WIDTH-1:0] acc, acc_next, in_ext;
  logic [CNT_WIDTH-1:0]        count, count_next;
  logic                        accept;
  logic [DATA_WIDTH-1:0]       sat_data;
  logic                        sat_flag;
  logic [DATA_WIDTH-1:0]       out_data_q;
  logic [CNT_WIDTH-1:0]        out_count_q;
  logic                        out_sat_q;

  assign accept = bus.in_valid && (state == IDLE || state == ACCUM);

  // The first word of a vector replaces the accumulator so no stale sum leaks in.
  always_comb begin
    in_ext     = ACC_WIDTH'(signed'(bus.in_data));
    acc_next   = (state == IDLE) ? in_ext : acc + in_ext;
    count_next = (state == IDLE) ? CNT_WIDTH'(1) : count + CNT_WIDTH'(1);
  end

  fixed_saturate #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_sat (
    .value  (acc_next),
    .result (sat_data),
    .sat    (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept)
          next_state = (bus.in_last || N_IN == 1) ? DONE : ACCUM;
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (accept && (bus.in_last || count_next == CNT_WIDTH'(N_IN)))
          next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      count       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_next;
      count <= count_next;
      if (next_state == DONE) begin
        out_data_q  <= sat_data;
        out_count_q <= count_next;
        out_sat_q   <= sat_flag;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_stream_vector_accumulator.sv
// Bench for stream_vector_accumulator: directed vectors plus random gapped
// streams, checked against a plain integer sum with saturation.
module tb_stream_vector_accumulator;
  import lstm_fixed_pkg::*;

  localparam int DW = 16;
  localparam int N  = 500;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stream_vector_accumulator_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  stream_vector_accumulator #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .N_IN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [26:0] obs = {bus.out_valid, bus.out_data, bus.out_count, bus.out_sat};

  // Expected {valid, data, count, sat} for a vector whose exact sum is 'sum'.
  function automatic logic [26:0] expect_vec(input longint sum, input int n);
    logic [15:0] d;
    logic        s;
    if (sum > 32767)       begin d = FIXED_MAX;  s = 1'b1; end
    else if (sum < -32768) begin d = FIXED_MIN;  s = 1'b1; end
    else                   begin d = 16'(sum);   s = 1'b0; end
    return {1'b1, d, 9'(n), s};
  endfunction

  // Present one word and return just after the edge that accepts it.
  task automatic drive_beat(input logic [15:0] d, input logic last);
    int waited = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < 50);
    total++;
    if (!bus.in_ready) begin
      bad++;
      $display("FAIL accept_wait in_ready=%b after %0d cycles, want 1", bus.in_ready, waited);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int k);
    bus.in_valid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({obs, bus.in_ready} !== {1'b0, 16'h0, 9'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got=%h in_ready=%b want=0000000 in_ready=1", obs, bus.in_ready);
    end
  endtask

  task automatic test_full_saturate;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) drive_beat(16'h0100, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== expect_vec(longint'(N) * 256, N)) begin
      bad++;
      $display("FAIL full_sat got=%h want=%h", obs, expect_vec(longint'(N) * 256, N));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed;
    logic [15:0] w [4] = '{16'h0180, 16'h0080, 16'hFF00, 16'h0040};
    for (int i = 0; i < 4; i++) drive_beat(w[i], i == 3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({obs, bus.in_ready} !== {expect_vec(320, 4), 1'b0}) begin
      bad++;
      $display("FAIL mixed got=%h in_ready=%b want=%h in_ready=0", obs, bus.in_ready, expect_vec(320, 4));
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL mixed_release out_valid,in_ready=%b want 01", {bus.out_valid, bus.in_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_neg_saturate;
    for (int i = 0; i < 200; i++) drive_beat(16'h8000, i == 199);
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== expect_vec(-32768 * 200, 200)) begin
      bad++;
      $display("FAIL neg_sat got=%h want=%h", obs, expect_vec(-32768 * 200, 200));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    drive_beat(16'h0200, 1'b0);
    bus.out_ready = 1'b0;
    drive_beat(16'h0300, 1'b1);
    bus.in_data = 16'h0111; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({obs, bus.in_ready} !== {expect_vec(1280, 2), 1'b0}) begin
        bad++;
        $display("FAIL hold_%0d got=%h in_ready=%b want=%h in_ready=0", i, obs, bus.in_ready, expect_vec(1280, 2));
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive_beat(16'h0111, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== expect_vec(273, 1)) begin
      bad++;
      $display("FAIL after_hold got=%h want=%h", obs, expect_vec(273, 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    for (int i = 0; i < 3; i++) drive_beat(16'h0100, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL abort_idle_%0d out_valid,in_ready=%b want 01", i, {bus.out_valid, bus.in_ready});
      end
    end
    @(posedge clk); #1;
    drive_beat(16'h0010, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== expect_vec(16, 1)) begin
      bad++;
      $display("FAIL abort_next got=%h want=%h", obs, expect_vec(16, 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_gaps;
    longint      sum;
    logic [15:0] w;
    int          len;
    // full-length vector of arbitrary words, in_last also set on word N
    sum = 0;
    for (int i = 0; i < N; i++) begin
      idle_cycles($urandom_range(0, 1));
      w = 16'($urandom);
      sum += longint'($signed(w));
      drive_beat(w, i == N - 1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== expect_vec(sum, N)) begin
      bad++;
      $display("FAIL rand_full got=%h want=%h", obs, expect_vec(sum, N));
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL rand_single_term out_valid,in_ready=%b want 01", {bus.out_valid, bus.in_ready});
      end
    end
    @(posedge clk); #1;
    // short vectors of small words that should not saturate
    for (int v = 0; v < 4; v++) begin
      sum = 0;
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        idle_cycles($urandom_range(0, 1));
        w = 16'(int'($urandom_range(0, 1023)) - 512);
        sum += longint'($signed(w));
        drive_beat(w, i == len - 1);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== expect_vec(sum, len)) begin
        bad++;
        $display("FAIL rand_short_%0d got=%h want=%h", v, obs, expect_vec(sum, len));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_full_saturate;
    test_mixed;
    test_neg_saturate;
    test_backpressure;
    test_reset_abort;
    test_random_gaps;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
